// File: rtl/sseg_array.sv
// Multi-digit seven-segment driver: shadowed config, LZB, blink, active-low registered outputs.
// Latency: load -> led after one more edge; no backpressure (load is a plain strobe).
module sseg_array #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     en_i,
  input  logic                  lzb_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  output logic [8*DIGITS-1:0]   led_o,
  output logic                  blink_phase_o
);

  localparam int CW = $clog2(BLINK_DIV + 1);

  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q, en_q, mask_q;
  logic                lzb_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [8*DIGITS-1:0] led_q, led_d;
  logic [DIGITS-1:0]   blank_lz;
  logic                run;
  logic                lit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h27;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h58;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dp_q   <= '0;
      en_q   <= '0;
      mask_q <= '0;
      lzb_q  <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      dp_q   <= dp_i;
      en_q   <= en_i;
      mask_q <= blink_mask_i;
      lzb_q  <= lzb_i;
    end
  end

  // A load restarts the blink cycle in the lit phase, overriding terminal count.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    run      = lzb_q;
    blank_lz = '0;
    lit      = 1'b0;
    led_d    = '1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && data_q[4*i +: 4] == 4'h0 && !dp_q[i]) blank_lz[i] = 1'b1;
      else                                              run = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) begin
      lit = en_q[i] && !(mask_q[i] && !phase_q) && !blank_lz[i];
      led_d[8*i +: 8] = lit ? ~{dp_q[i], seg7(data_q[4*i +: 4])} : 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '1;
    else        led_q <= led_d;
  end

  assign led_o         = led_q;
  assign blink_phase_o = phase_q;

endmodule

// File: tb/tb_sseg_array.sv
// Randomized bench for sseg_array with a behavioural display model and literal anchor checks.
module tb_sseg_array;
  localparam int D   = 6;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [23:0]   data;
  logic [5:0]    dp, en, mask;
  logic          lzb;
  logic [47:0]   led;
  logic          blink_phase;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  sseg_array #(.DIGITS(D), .BLINK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load), .data_i(data), .dp_i(dp), .en_i(en),
    .lzb_i(lzb), .blink_mask_i(mask), .led_o(led), .blink_phase_o(blink_phase)
  );

  always #5 clk = ~clk;

  // Model state: shadow copy plus edges elapsed since the last blink restart.
  logic [23:0] m_data;
  logic [5:0]  m_dp, m_en, m_mask;
  logic        m_lzb;
  int          m_t;
  logic [47:0] exp_led;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  function automatic logic model_phase(input int t);
    return ((t / DIV) % 2) == 0;
  endfunction

  function automatic logic [47:0] model_led(input logic [23:0] d, input logic [5:0] p,
                                            input logic [5:0] e, input logic [5:0] m,
                                            input logic l, input logic ph);
    logic [47:0] r;
    int top;
    top = 0;
    for (int i = 0; i < D; i++)
      if (d[4*i +: 4] != 4'h0 || p[i]) top = i;
    for (int i = 0; i < D; i++) begin
      if (e[i] && !(m[i] && !ph) && (!l || i <= top))
        r[8*i +: 8] = ~{p[i], glyph(d[4*i +: 4])};
      else
        r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data = '0; m_dp = '0; m_en = '0; m_mask = '0; m_lzb = 1'b0;
      m_t = 0;
      exp_led = '1;
    end else begin
      exp_led = model_led(m_data, m_dp, m_en, m_mask, m_lzb, model_phase(m_t));
      if (load) begin
        m_data = data; m_dp = dp; m_en = en; m_mask = mask; m_lzb = lzb;
        m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (led !== exp_led || blink_phase !== model_phase(m_t)) begin
        n_bad++;
        $display("FAIL model t=%0t led=%h exp=%h phase=%b exp=%b", $time, led, exp_led,
                 blink_phase, model_phase(m_t));
      end
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic rand_inputs();
    data = $urandom; dp = 6'($urandom); en = 6'($urandom);
    mask = 6'($urandom); lzb = 1'($urandom);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] e, input logic [5:0] p,
                         input logic l, input logic [5:0] m);
    @(posedge clk); #1;
    load = 1'b1; data = d; en = e; dp = p; lzb = l; mask = m;
    @(posedge clk); #1;
    load = 1'b0; rand_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; rand_inputs();
    #2 chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; load = 1'($urandom); rand_inputs();
    end
    #1;
    check("reset_led", led, '1);
    check("reset_phase", {47'b0, blink_phase}, 48'd1);
    load = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("release_led", led, '1);

    do_load(24'h00A05F, 6'h3F, 6'h00, 1'b1, 6'h00);
    check("decode_lzb", led, 48'hFFFF88C0928E);
    do_load(24'h000000, 6'h3F, 6'h00, 1'b1, 6'h00);
    check("allzero_lzb", led, 48'hFFFFFFFFFFC0);
    do_load(24'h000000, 6'h3F, 6'h04, 1'b1, 6'h00);
    check("allzero_dp", led, 48'hFFFFFF40C0C0);
    do_load(24'h888888, 6'h2A, 6'h3F, 1'b0, 6'h00);
    check("en_dp", led, 48'h00FF00FF00FF);

    // Blink: load edge k, now just after k+1.
    do_load(24'h000001, 6'h3F, 6'h00, 1'b0, 6'h01);
    check("blink_lit", led, 48'hC0C0C0C0C0F9);
    repeat (3) @(posedge clk);
    #1 check("blink_off_phase", {47'b0, blink_phase}, 48'd0);
    @(posedge clk); #1;
    check("blink_dark", led, 48'hC0C0C0C0C0FF);
    do_load(24'h000001, 6'h3F, 6'h00, 1'b0, 6'h01);
    check("reload_lit", led, 48'hC0C0C0C0C0F9);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midblink_rst_led", led, '1);
    check("midblink_rst_phase", {47'b0, blink_phase}, 48'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("restart_phase_hi", {47'b0, blink_phase}, 48'd1);
    @(posedge clk); #1;
    check("restart_phase_lo", {47'b0, blink_phase}, 48'd0);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(150) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      load = ($urandom_range(5) == 0);
      rand_inputs();
      data = data >> (4 * $urandom_range(6));
      if ($urandom_range(3) == 0) dp = '0;
    end
    @(posedge clk); #1 load = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
